pc_controller: RTL and testbench
================================

PC_CONTROLLER -- requirements
Module: pc_controller

Interface
REQ-001 Parameter RESET_VECTOR, default 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter PC_INCREMENT, default 4, sequential fetch step in bytes.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 stall  input  1  hazard hold; PC must not advance.
REQ-006 alu_branch  input  1  branch condition true from ALU.
REQ-007 control_branch  input  1  current instruction is a conditional branch.
REQ-008 branch_target  input  32  conditional branch destination.
REQ-009 jump  input  1  unconditional jump (JAL/JALR) resolved.
REQ-010 jump_target  input  32  jump destination.
REQ-011 halt  input  1  halt instruction retiring.
REQ-012 resume  input  1  leave HALT state.
REQ-013 pc  output  32  current fetch address, registered.
REQ-014 pc_valid  output  1  fetch at pc is live this cycle, registered.
REQ-015 flush  output  1  kill the instruction in decode this cycle, registered.
REQ-016 halted  output  1  controller in HALT, registered.
REQ-017 misaligned  output  1  one-cycle pulse: accepted redirect target had bits[1:0] != 0.

Function
REQ-018 The controller SHALL implement states RUN, FLUSH, HALT.
REQ-019 taken = alu_branch AND control_branch; redirect = jump OR taken.
REQ-020 Per-cycle priority in RUN/FLUSH SHALL be: halt > redirect > stall > increment.
REQ-021 Target selection: jump=1 SHALL select jump_target; otherwise branch_target.
REQ-022 On redirect, pc SHALL load the target with bits[1:0] forced to 0, and misaligned SHALL pulse the next cycle if the raw bits were nonzero.
REQ-023 On redirect, state SHALL go to FLUSH; flush=1 for exactly the cycle in which pc first shows the target.
REQ-024 Redirect accepted while in FLUSH SHALL load the new target and hold flush=1 for one more cycle.
REQ-025 Redirect SHALL override stall in the same cycle (wrong-path instruction is stalled).
REQ-026 FLUSH with no new redirect SHALL return to RUN next cycle; stall in FLUSH holds pc but does not extend flush.
REQ-027 Increment: pc <= pc + PC_INCREMENT, modulo 2^32 (32'hFFFF_FFFC + 4 wraps to 0).
REQ-028 stall without redirect/halt SHALL hold pc unchanged; pc_valid stays 1.
REQ-029 halt in RUN/FLUSH SHALL hold pc, enter HALT next cycle: halted=1, pc_valid=0, flush=0.
REQ-030 In HALT, redirect and stall SHALL be ignored; resume SHALL set pc <= pc + PC_INCREMENT, state RUN, halted=0, pc_valid=1.
REQ-031 halt and resume asserted together in HALT: resume wins.
REQ-032 pc_valid SHALL be 1 in every RUN or FLUSH cycle after the first post-reset cycle.

Reset
REQ-033 reset=1 at a rising edge SHALL set pc=RESET_VECTOR, state=RUN, pc_valid=0, flush=0, halted=0, misaligned=0, overriding all other inputs including mid-FLUSH or HALT.
REQ-034 The first edge with reset=0 SHALL set pc_valid=1 with pc still RESET_VECTOR; normal priority applies from that edge.

Structure
REQ-035 Shared package SHALL hold WORD_SIZE=32, the state enum (RUN, FLUSH, HALT) and the default PC_INCREMENT.
REQ-036 Combinational next-PC selection SHALL be one sub-module, pc_next_sel; the state machine and registers live in pc_controller.

Verification
REQ-037 Reset release, no events, 4 cycles -> pc 0x0, 0x0 (pc_valid=1), 0x4, 0x8, 0xC.
REQ-038 At pc=0x10, alu_branch=control_branch=1, branch_target=0x40 -> next cycle pc=0x40, flush=1; following cycle pc=0x44, flush=0.
REQ-039 Same-cycle stall=1 and jump=1, jump_target=0x103 -> pc=0x100, flush=1, misaligned=1 one cycle.
REQ-040 Back-to-back redirects to 0x200 then 0x300 -> flush high two consecutive cycles, pc 0x200 then 0x300.
REQ-041 halt at pc=0x20 with redirect also asserted -> halted=1, pc stays 0x20, pc_valid=0; resume -> pc=0x24, RUN.
REQ-042 pc=32'hFFFF_FFFC, increment -> pc=0x0; reset asserted during FLUSH -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/pc_controller_pkg.sv
// Shared types and constants for the program-counter controller.
// Pure declarations, no logic and no latency.
// No flow control here. The package only defines the word width, the state enum and the default fetch step.
package pc_controller_pkg;

    localparam int unsigned WORD_SIZE = 32;

    // Sequential fetch step in bytes (one 32-bit instruction).
    localparam logic [WORD_SIZE-1:0] PC_INCREMENT_DEFAULT = 32'd4;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_HALT  = 2'd2
    } pc_state_e;

    // Redirect targets are forced onto a word boundary.
    function automatic logic [WORD_SIZE-1:0] word_align(input logic [WORD_SIZE-1:0] addr);
        return {addr[WORD_SIZE-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC selection: picks hold / redirect target / sequential PC by priority halt > redirect > stall > increment.
// Purely combinational, zero cycles.
// No handshake. Stall and halt simply select the current PC.
// Ports:
//   pc_i                        current fetch address
//   stall_i, halt_i             hold requests
//   alu_branch_i, control_branch_i, branch_target_i   conditional branch inputs
//   jump_i, jump_target_i       unconditional jump inputs
//   redirect_o                  jump or taken branch this cycle
//   misaligned_o                raw selected target has nonzero low bits
//   seq_pc_o                    pc_i + PC_INCREMENT (wraps modulo 2^32)
//   next_pc_o                   prioritised next PC while running
module pc_next_sel
    import pc_controller_pkg::*;
#(
    parameter logic [WORD_SIZE-1:0] PC_INCREMENT = PC_INCREMENT_DEFAULT
) (
    input  logic [WORD_SIZE-1:0] pc_i,
    input  logic                 stall_i,
    input  logic                 halt_i,
    input  logic                 alu_branch_i,
    input  logic                 control_branch_i,
    input  logic [WORD_SIZE-1:0] branch_target_i,
    input  logic                 jump_i,
    input  logic [WORD_SIZE-1:0] jump_target_i,
    output logic                 redirect_o,
    output logic                 misaligned_o,
    output logic [WORD_SIZE-1:0] seq_pc_o,
    output logic [WORD_SIZE-1:0] next_pc_o
);

    logic [WORD_SIZE-1:0] raw_target;
    logic                 taken;

    always_comb begin
        // A jump always wins the target mux, even if a branch is also taken.
        raw_target   = jump_i ? jump_target_i : branch_target_i;
        taken        = alu_branch_i & control_branch_i;
        redirect_o   = jump_i | taken;
        misaligned_o = |raw_target[1:0];
        seq_pc_o     = pc_i + PC_INCREMENT;

        if (halt_i) begin
            next_pc_o = pc_i;
        end else if (redirect_o) begin
            next_pc_o = word_align(raw_target);
        end else if (stall_i) begin
            next_pc_o = pc_i;
        end else begin
            next_pc_o = seq_pc_o;
        end
    end

endmodule

// File: rtl/pc_controller.sv
// Program-counter controller with RUN / FLUSH / HALT states, redirect flush and misalignment pulse.
// All outputs registered. A redirect shows its target (with flush) one cycle after it is presented.
// stall holds pc without dropping pc_valid. halt parks the controller until resume.
// Ports:
//   clk, reset                  single clock, synchronous active-high reset
//   stall, halt, resume         hold / park / unpark requests
//   alu_branch, control_branch, branch_target   conditional branch
//   jump, jump_target           unconditional jump
//   pc, pc_valid, flush, halted, misaligned     registered status outputs
module pc_controller
    import pc_controller_pkg::*;
#(
    parameter logic [WORD_SIZE-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [WORD_SIZE-1:0] PC_INCREMENT = PC_INCREMENT_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 stall,
    input  logic                 alu_branch,
    input  logic                 control_branch,
    input  logic [WORD_SIZE-1:0] branch_target,
    input  logic                 jump,
    input  logic [WORD_SIZE-1:0] jump_target,
    input  logic                 halt,
    input  logic                 resume,
    output logic [WORD_SIZE-1:0] pc,
    output logic                 pc_valid,
    output logic                 flush,
    output logic                 halted,
    output logic                 misaligned
);

    pc_state_e            state_q;
    logic [WORD_SIZE-1:0] pc_q;
    logic                 pc_valid_q;
    logic                 flush_q;
    logic                 halted_q;
    logic                 misaligned_q;

    logic [WORD_SIZE-1:0] pc_d;
    logic [WORD_SIZE-1:0] seq_pc;
    logic                 redirect;
    logic                 target_misaligned;

    pc_next_sel #(
        .PC_INCREMENT (PC_INCREMENT)
    ) u_next_sel (
        .pc_i             (pc_q),
        .stall_i          (stall),
        .halt_i           (halt),
        .alu_branch_i     (alu_branch),
        .control_branch_i (control_branch),
        .branch_target_i  (branch_target),
        .jump_i           (jump),
        .jump_target_i    (jump_target),
        .redirect_o       (redirect),
        .misaligned_o     (target_misaligned),
        .seq_pc_o         (seq_pc),
        .next_pc_o        (pc_d)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_RUN;
            pc_q         <= RESET_VECTOR;
            pc_valid_q   <= 1'b0;
            flush_q      <= 1'b0;
            halted_q     <= 1'b0;
            misaligned_q <= 1'b0;
        end else begin
            // flush and misaligned are single-cycle unless re-armed below.
            flush_q      <= 1'b0;
            misaligned_q <= 1'b0;
            case (state_q)
                ST_HALT: begin
                    // Only resume matters here. It beats a simultaneous halt.
                    if (resume) begin
                        pc_q       <= seq_pc;
                        state_q    <= ST_RUN;
                        halted_q   <= 1'b0;
                        pc_valid_q <= 1'b1;
                    end
                end
                default: begin
                    if (!pc_valid_q) begin
                        // RUN with pc_valid low only happens on the first edge out of reset.
                        // That edge presents RESET_VECTOR as a live fetch without advancing.
                        pc_valid_q <= 1'b1;
                    end else begin
                        pc_q <= pc_d;
                        if (halt) begin
                            state_q    <= ST_HALT;
                            halted_q   <= 1'b1;
                            pc_valid_q <= 1'b0;
                        end else if (redirect) begin
                            state_q      <= ST_FLUSH;
                            flush_q      <= 1'b1;
                            misaligned_q <= target_misaligned;
                        end else begin
                            state_q <= ST_RUN;
                        end
                    end
                end
            endcase
        end
    end

    assign pc         = pc_q;
    assign pc_valid   = pc_valid_q;
    assign flush      = flush_q;
    assign halted     = halted_q;
    assign misaligned = misaligned_q;

endmodule

// File: tb/tb_pc_controller.sv
module tb_pc_controller;

    localparam logic [31:0] RV  = 32'h0000_0000;
    localparam logic [31:0] INC = 32'd4;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        alu_branch;
    logic        control_branch;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic        halt;
    logic        resume;
    logic [31:0] pc;
    logic        pc_valid;
    logic        flush;
    logic        halted;
    logic        misaligned;

    int total = 0;
    int bad   = 0;

    // Behavioural model: what software would observe, not how the RTL stores it.
    logic [31:0] m_pc;
    logic        m_valid;
    logic        m_flush;
    logic        m_halted;
    logic        m_mis;
    logic        m_fresh;   // next edge is the first one after reset release

    pc_controller #(
        .RESET_VECTOR (RV),
        .PC_INCREMENT (INC)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .alu_branch     (alu_branch),
        .control_branch (control_branch),
        .branch_target  (branch_target),
        .jump           (jump),
        .jump_target    (jump_target),
        .halt           (halt),
        .resume         (resume),
        .pc             (pc),
        .pc_valid       (pc_valid),
        .flush          (flush),
        .halted         (halted),
        .misaligned     (misaligned)
    );

    always #5 clk = ~clk;

    task automatic model_edge();
        logic        redir;
        logic [31:0] tgt;
        if (reset) begin
            m_pc = RV; m_valid = 1'b0; m_flush = 1'b0;
            m_halted = 1'b0; m_mis = 1'b0; m_fresh = 1'b1;
            return;
        end
        redir   = jump || (alu_branch && control_branch);
        tgt     = jump ? jump_target : branch_target;
        m_flush = 1'b0;
        m_mis   = 1'b0;
        if (m_halted) begin
            if (resume) begin
                m_pc = m_pc + INC; m_halted = 1'b0; m_valid = 1'b1;
            end
        end else if (m_fresh) begin
            m_fresh = 1'b0; m_valid = 1'b1;
        end else if (halt) begin
            m_halted = 1'b1; m_valid = 1'b0;
        end else if (redir) begin
            m_pc    = tgt & 32'hFFFF_FFFC;
            m_flush = 1'b1;
            m_mis   = (tgt % 4) != 0;
        end else if (!stall) begin
            m_pc = m_pc + INC;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, "_pc"},       pc,                 m_pc);
        check({tag, "_valid"},    {31'd0, pc_valid},  {31'd0, m_valid});
        check({tag, "_flush"},    {31'd0, flush},     {31'd0, m_flush});
        check({tag, "_halted"},   {31'd0, halted},    {31'd0, m_halted});
        check({tag, "_mis"},      {31'd0, misaligned},{31'd0, m_mis});
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_model(tag);
    endtask

    task automatic idle();
        reset = 1'b0; stall = 1'b0; alu_branch = 1'b0; control_branch = 1'b0;
        jump = 1'b0; halt = 1'b0; resume = 1'b0;
        branch_target = 32'h0; jump_target = 32'h0;
    endtask

    initial begin
        m_pc = RV; m_valid = 1'b0; m_flush = 1'b0;
        m_halted = 1'b0; m_mis = 1'b0; m_fresh = 1'b1;
        idle();
        reset = 1'b1;
        step("rst0");
        step("rst1");
        check("rst_pc", pc, 32'h0);
        check("rst_valid", {31'd0, pc_valid}, 32'd0);

        // Reset release: 0 (valid), 4, 8, C
        idle();
        step("rel0"); check("rel0_pc_c", pc, 32'h0); check("rel0_valid_c", {31'd0, pc_valid}, 32'd1);
        step("rel1"); check("rel1_pc_c", pc, 32'h4);
        step("rel2"); check("rel2_pc_c", pc, 32'h8);
        step("rel3"); check("rel3_pc_c", pc, 32'hC);
        step("rel4"); check("rel4_pc_c", pc, 32'h10);

        // Taken branch at 0x10 to 0x40
        alu_branch = 1'b1; control_branch = 1'b1; branch_target = 32'h40;
        step("br0"); check("br_pc_c", pc, 32'h40); check("br_flush_c", {31'd0, flush}, 32'd1);
        idle();
        step("br1"); check("br1_pc_c", pc, 32'h44); check("br1_flush_c", {31'd0, flush}, 32'd0);

        // Stall + misaligned jump: redirect wins
        stall = 1'b1; jump = 1'b1; jump_target = 32'h103;
        step("jm0"); check("jm_pc_c", pc, 32'h100); check("jm_mis_c", {31'd0, misaligned}, 32'd1);
        check("jm_flush_c", {31'd0, flush}, 32'd1);
        idle();
        step("jm1"); check("jm1_mis_c", {31'd0, misaligned}, 32'd0);

        // Back-to-back redirects
        jump = 1'b1; jump_target = 32'h200;
        step("bb0"); check("bb0_pc_c", pc, 32'h200);
        jump_target = 32'h300;
        step("bb1"); check("bb1_pc_c", pc, 32'h300); check("bb1_flush_c", {31'd0, flush}, 32'd1);
        idle();
        step("bb2"); check("bb2_flush_c", {31'd0, flush}, 32'd0);

        // Halt at 0x20 with a redirect present, ignore events in HALT, then resume
        jump = 1'b1; jump_target = 32'h20;
        step("h0");
        halt = 1'b1; jump_target = 32'h500;
        step("h1"); check("h1_pc_c", pc, 32'h20); check("h1_halted_c", {31'd0, halted}, 32'd1);
        check("h1_valid_c", {31'd0, pc_valid}, 32'd0);
        halt = 1'b0; stall = 1'b1; alu_branch = 1'b1; control_branch = 1'b1; branch_target = 32'h600;
        step("h2"); check("h2_pc_c", pc, 32'h20);
        idle(); halt = 1'b1; resume = 1'b1;
        step("h3"); check("h3_pc_c", pc, 32'h24); check("h3_halted_c", {31'd0, halted}, 32'd0);
        idle();
        step("h4"); check("h4_pc_c", pc, 32'h28);

        // Wrap at top of address space
        jump = 1'b1; jump_target = 32'hFFFF_FFFC;
        step("w0");
        idle();
        step("w1"); check("w1_pc_c", pc, 32'h0);

        // Reset during FLUSH
        jump = 1'b1; jump_target = 32'h80;
        step("rf0");
        reset = 1'b1;
        step("rf1"); check("rf1_pc_c", pc, 32'h0); check("rf1_flush_c", {31'd0, flush}, 32'd0);
        check("rf1_valid_c", {31'd0, pc_valid}, 32'd0);
        idle();
        step("rf2");

        // Randomised phase against the model
        for (int i = 0; i < 800; i++) begin
            reset          = ($urandom_range(0, 99) < 2);
            stall          = ($urandom_range(0, 3) == 0);
            halt           = ($urandom_range(0, 15) == 0);
            resume         = ($urandom_range(0, 3) == 0);
            jump           = ($urandom_range(0, 7) == 0);
            alu_branch     = ($urandom_range(0, 1) == 1);
            control_branch = ($urandom_range(0, 3) == 0);
            branch_target  = $urandom;
            jump_target    = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
            if (m_fresh) begin
                halt = 1'b0; jump = 1'b0; control_branch = 1'b0;
            end
            step("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
